mem_burst_splitter: RTL and testbench

MEM_BURST_SPLITTER -- requirements
Module: mem_burst_splitter

---
 rtl/mem_burst_splitter.sv | 103 ++++++++++
 tb/tb_mem_burst_splitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_splitter.sv
// Splits byte-addressed memory requests into chunks that never cross a
// 2^BOUNDARY_LOG2 boundary and never exceed 2^MAX_BURST_LOG2 bytes.
module mem_burst_splitter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16,
    parameter int BOUNDARY_LOG2  = 12,
    parameter int MAX_BURST_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [REQ_SIZE_WIDTH-1:0] in_size,
    input  logic                      split_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [REQ_SIZE_WIDTH-1:0] out_size,
    output logic                      out_first,
    output logic                      out_last,
    output logic [REQ_SIZE_WIDTH-1:0] chunk_idx,
    output logic                      busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    // Wide enough for both the remaining count and the distance to the boundary.
    localparam int CW = ((REQ_SIZE_WIDTH > BOUNDARY_LOG2) ? REQ_SIZE_WIDTH : BOUNDARY_LOG2) + 1;

    logic [0:0]                state_reg;
    logic [ADDR_WIDTH-1:0]     cur_addr_reg;
    logic [REQ_SIZE_WIDTH-1:0] remaining_reg;
    logic [REQ_SIZE_WIDTH-1:0] chunk_idx_reg;
    logic                      mode_reg;

    logic [CW-1:0]             rem_ext;
    logic [CW-1:0]             bnd_room;
    logic [CW-1:0]             max_burst;
    logic [CW-1:0]             split_size;
    logic [REQ_SIZE_WIDTH-1:0] chunk_size;

    always_comb begin
        rem_ext    = CW'(remaining_reg);
        bnd_room   = (CW'(1) << BOUNDARY_LOG2) - CW'(cur_addr_reg[BOUNDARY_LOG2-1:0]);
        max_burst  = CW'(1) << MAX_BURST_LOG2;
        split_size = rem_ext;
        if (bnd_room < split_size) begin
            split_size = bnd_room;
        end
        if (max_burst < split_size) begin
            split_size = max_burst;
        end
        // split_size never exceeds remaining, so truncation is lossless.
        chunk_size = mode_reg ? REQ_SIZE_WIDTH'(split_size) : remaining_reg;
    end

    assign in_ready  = (state_reg == IDLE) && reset;
    assign out_valid = (state_reg == ISSUE);
    assign busy      = (state_reg == ISSUE);
    assign out_addr  = cur_addr_reg;
    assign out_size  = chunk_size;
    assign chunk_idx = chunk_idx_reg;
    assign out_first = (chunk_idx_reg == '0);
    assign out_last  = (chunk_size == remaining_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            chunk_idx_reg <= '0;
            mode_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Zero-length requests are consumed without producing a chunk.
                    if (in_valid && (in_size != '0)) begin
                        cur_addr_reg  <= in_addr;
                        remaining_reg <= in_size;
                        mode_reg      <= split_en;
                        chunk_idx_reg <= '0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_reg <= IDLE;
                        end else begin
                            cur_addr_reg  <= cur_addr_reg + ADDR_WIDTH'(chunk_size);
                            remaining_reg <= remaining_reg - chunk_size;
                            chunk_idx_reg <= chunk_idx_reg + REQ_SIZE_WIDTH'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Randomized and directed checks of mem_burst_splitter against a chunk-list
// model computed directly from the splitting rules.
module tb_mem_burst_splitter;

    localparam int AW = 64;
    localparam int SW = 16;
    localparam int BL = 12;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [SW-1:0] in_size = '0;
    logic          split_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [SW-1:0] out_size;
    logic          out_first;
    logic          out_last;
    logic [SW-1:0] chunk_idx;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic [63:0] eq_addr[$];
    int          eq_size[$];

    mem_burst_splitter #(
        .ADDR_WIDTH(AW),
        .REQ_SIZE_WIDTH(SW),
        .BOUNDARY_LOG2(BL),
        .MAX_BURST_LOG2(ML)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_addr(in_addr),
        .in_size(in_size),
        .split_en(split_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr(out_addr),
        .out_size(out_size),
        .out_first(out_first),
        .out_last(out_last),
        .chunk_idx(chunk_idx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected chunk list: repeatedly take the smallest of what is left, the
    // room to the next 4 KiB boundary and the 256-byte burst limit.
    task automatic build_model(input logic [63:0] a, input int size, input bit split);
        logic [63:0] cur;
        int rem;
        int room;
        int c;
        eq_addr.delete();
        eq_size.delete();
        cur = a;
        rem = size;
        while (rem > 0) begin
            if (split) begin
                room = (1 << BL) - int'(cur % (64'd1 << BL));
                c = rem;
                if (room < c) c = room;
                if ((1 << ML) < c) c = 1 << ML;
            end else begin
                c = rem;
            end
            eq_addr.push_back(cur);
            eq_size.push_back(c);
            cur = cur + 64'(c);
            rem = rem - c;
        end
    endtask

    task automatic run_req(input logic [63:0] a, input int size, input bit split,
                           input int hold, input bit rnd_bp);
        int cycles;
        int idx;
        int nchunks;
        bit rdy;
        build_model(a, size, split);
        nchunks = eq_addr.size();
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_addr  = a;
        in_size  = SW'(size);
        split_en = split;
        @(negedge clk);
        in_valid = 1'b0;
        split_en = 1'($urandom_range(0, 1));
        in_addr  = {$urandom, $urandom};
        in_size  = 16'($urandom);
        cycles = 0;
        idx = 0;
        while (eq_addr.size() > 0 && cycles < 400) begin
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_addr", out_addr, eq_addr[0]);
            check("out_size", 64'(out_size), 64'(eq_size[0]));
            check("out_first", 64'(out_first), 64'(idx == 0));
            check("out_last", 64'(out_last), 64'(eq_addr.size() == 1));
            check("chunk_idx", 64'(chunk_idx), 64'(idx));
            check("busy", 64'(busy), 64'd1);
            check("in_ready_issue", 64'(in_ready), 64'd0);
            if (cycles < hold) rdy = 1'b0;
            else if (rnd_bp) rdy = 1'($urandom_range(0, 1));
            else rdy = 1'b1;
            out_ready = rdy;
            // Stray in_valid while issuing must be ignored; drop it before the
            // final handshake so it is not taken as a new request.
            in_valid = (rdy && eq_addr.size() == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk);
            if (rdy) begin
                void'(eq_addr.pop_front());
                void'(eq_size.pop_front());
                idx++;
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("chunks_left", 64'(eq_addr.size()), 64'd0);
        check("bubble_valid", 64'(out_valid), 64'd0);
        check("bubble_in_ready", 64'(in_ready), 64'd1);
        check("bubble_busy", 64'(busy), 64'd0);
        $display("req addr=0x%016h size=0x%0h split=%0d chunks=%0d cycles=%0d",
                 a, size, split, nchunks, cycles);
    endtask

    task automatic reset_mid_request();
        build_model(64'h1000, 'h300, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 64'h1000;
        in_size  = 16'h0300;
        split_en = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("rst_pre_addr", out_addr, eq_addr[1]);
        check("rst_pre_idx", 64'(chunk_idx), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_addr", out_addr, 64'd0);
        check("rst_out_size", 64'(out_size), 64'd0);
        check("rst_chunk_idx", 64'(chunk_idx), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        $display("reset mid-request at chunk 1 of 0x1000/0x300");
    endtask

    initial begin
        #1;
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("init_busy", 64'(busy), 64'd0);
        check("init_chunk_idx", 64'(chunk_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_req(64'h0FC0, 'h80, 1'b1, 0, 1'b0);
        run_req(64'h1000, 'h300, 1'b1, 0, 1'b0);
        run_req(64'h0FF0, 'h20, 1'b1, 5, 1'b0);
        run_req(64'h0FC0, 'h300, 1'b0, 0, 1'b0);
        run_req(64'h2000, 0, 1'b1, 0, 1'b0);
        run_req(64'h3000, 'h100, 1'b1, 0, 1'b0);
        run_req(64'hFFFF_FFFF_FFFF_FFC0, 'h80, 1'b1, 0, 1'b0);

        reset_mid_request();
        run_req(64'h1000, 'h300, 1'b1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a;
            int size;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'($urandom_range(3900, 4095));
            size = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 'h600));
            run_req(a, size, 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
